// File: rtl/ddr_pixel_serializer.sv
// Byte-stream to DDR bit-pair serializer: a 2-entry input FIFO feeding a shift
// register that emits one MSB-first bit pair per clk into a two-bit DDR output cell.
module ddr_pixel_serializer #(
    parameter int   DATA_W     = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              blank,
    output logic [1:0]        ddr_din,
    output logic              busy,
    output logic              underrun,
    output logic [7:0]        underrun_cnt,
    input  logic              clr_underrun
);

    localparam int SLOTS = DATA_W / 2;
    localparam int CNT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
    localparam logic [1:0] IDLE_PAIR = {IDLE_LEVEL, IDLE_LEVEL};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [DATA_W-1:0]  shreg, shreg_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [1:0]         ddr_next;
    logic               underrun_next;

    logic [DATA_W-1:0]  buf_mem [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         fill;
    logic               active;
    logic               push, pop, do_load;
    logic [DATA_W-1:0]  head;

    // Handshake: a byte transfers on a clk edge where s_valid & s_ready are both
    // high. s_ready depends only on registered state and en, never on a same-cycle
    // pop, so a full buffer refuses a push even on the edge that drains it.
    assign s_ready = active & en & (fill != 2'd2);
    assign push    = s_valid & s_ready;
    assign head    = buf_mem[rd_ptr];
    assign busy    = (state == SHIFT) | (fill != 2'd0);

    // ddr_din[0] carries the earlier (more significant) bit of the pair.
    function automatic logic [1:0] top_pair(input logic [DATA_W-1:0] d);
        return {d[DATA_W-2], d[DATA_W-1]};
    endfunction

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        cnt_next      = cnt;
        ddr_next      = ddr_din;
        underrun_next = 1'b0;
        do_load       = 1'b0;
        pop           = 1'b0;

        if (!en) begin
            state_next = IDLE;
            shreg_next = '0;
            cnt_next   = '0;
            ddr_next   = IDLE_PAIR;
        end else begin
            case (state)
                IDLE: begin
                    if (fill != 2'd0) begin
                        do_load = 1'b1;
                    end else begin
                        ddr_next = IDLE_PAIR;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST_SLOT) begin
                        ddr_next   = blank ? IDLE_PAIR : top_pair(shreg);
                        shreg_next = shreg << 2;
                        cnt_next   = cnt + CNT_W'(1);
                    end else if (fill != 2'd0) begin
                        do_load = 1'b1;
                    end else begin
                        // Stream broke after the last pair of a byte.
                        ddr_next      = IDLE_PAIR;
                        underrun_next = 1'b1;
                        state_next    = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    ddr_next   = IDLE_PAIR;
                end
            endcase

            if (do_load) begin
                ddr_next   = blank ? IDLE_PAIR : top_pair(head);
                shreg_next = head << 2;
                cnt_next   = '0;
                pop        = 1'b1;
                state_next = SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            ddr_din  <= IDLE_PAIR;
            underrun <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
            ddr_din  <= ddr_next;
            underrun <= underrun_next;
            active   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill       <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else if (!en) begin
            fill   <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= s_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 2'd1;
                2'b01:   fill <= fill - 2'd1;
                default: fill <= fill;
            endcase
        end
    end

    // Clear wins over a same-edge increment; the pulse itself is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= 8'd0;
        end else if (clr_underrun) begin
            underrun_cnt <= 8'd0;
        end else if (underrun_next && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule
